// File: rtl/power_seq.sv
// Purpose: sequences N_RAILS supply rails up in order (each qualified by a held power-good), down in reverse, and latches rail faults.
// Latency: rail_en[0] asserts on the edge that samples pwr_req high; each later rail asserts on the edge its predecessor qualifies.
// Backpressure: none; rail_good is live feedback and pwr_req is a level request, only honoured in IDLE/UP/ON/FAULT.
module power_seq #(
    parameter int N_RAILS     = 4,
    parameter int DELAY_CYC   = 30,
    parameter int TIMEOUT_CYC = 100
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               pwr_req,
    input  logic [N_RAILS-1:0] rail_good,
    output logic [N_RAILS-1:0] rail_en,
    output logic               all_good,
    output logic               fault,
    output logic [3:0]         fault_rail,
    output logic               busy
);

    localparam int MAX_CNT = (DELAY_CYC > TIMEOUT_CYC) ? DELAY_CYC : TIMEOUT_CYC;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int KW      = (N_RAILS > 1) ? $clog2(N_RAILS) : 1;

    // Compare against "last value before the limit" so the action lands on
    // the same edge the counter would reach the limit.
    localparam logic [CW-1:0]      DLY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0]      TMO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]      CNT_SAT  = '1;
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [KW-1:0]      K_LAST   = KW'(N_RAILS - 1);
    localparam logic [KW-1:0]      K_ONE    = KW'(1);
    localparam logic [N_RAILS-1:0] EN_ONE   = N_RAILS'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_ON    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [KW-1:0]      k, k_nxt;
    logic [CW-1:0]      qual_cnt, qual_nxt;
    // tmr_cnt is the timeout counter in UP and the power-down spacing counter in DOWN
    logic [CW-1:0]      tmr_cnt, tmr_nxt;
    logic [N_RAILS-1:0] rail_en_nxt;
    logic               fault_nxt;
    logic [3:0]         fault_rail_nxt;

    logic               lo_up_vld, lo_all_vld;
    logic [3:0]         lo_up_idx, lo_all_idx;
    logic               qual_hit;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_ONE;
    endfunction

    // Lowest rail reading low: among already-qualified rails (j<k) and among all rails
    always_comb begin
        lo_up_vld  = 1'b0;
        lo_up_idx  = '0;
        lo_all_vld = 1'b0;
        lo_all_idx = '0;
        for (int j = N_RAILS - 1; j >= 0; j--) begin
            if (!rail_good[j]) begin
                lo_all_vld = 1'b1;
                lo_all_idx = 4'(j);
                if (j < int'(k)) begin
                    lo_up_vld = 1'b1;
                    lo_up_idx = 4'(j);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and datapath-next logic; fault beats both qualification and power-down
    always_comb begin
        state_nxt      = state;
        k_nxt          = k;
        qual_nxt       = qual_cnt;
        tmr_nxt        = tmr_cnt;
        rail_en_nxt    = rail_en;
        fault_nxt      = fault;
        fault_rail_nxt = fault_rail;
        qual_hit       = rail_good[k] && (qual_cnt == DLY_LAST);

        case (state)
            S_IDLE: begin
                if (pwr_req) begin
                    state_nxt   = S_UP;
                    k_nxt       = '0;
                    qual_nxt    = '0;
                    tmr_nxt     = '0;
                    rail_en_nxt = EN_ONE;
                end
            end

            S_UP: begin
                if (lo_up_vld || (!qual_hit && tmr_cnt == TMO_LAST)) begin
                    // earlier rail collapsing is reported ahead of the current rail's timeout
                    state_nxt      = S_FAULT;
                    rail_en_nxt    = '0;
                    fault_nxt      = 1'b1;
                    fault_rail_nxt = lo_up_vld ? lo_up_idx : 4'(k);
                    k_nxt          = '0;
                    qual_nxt       = '0;
                    tmr_nxt        = '0;
                end else if (!pwr_req) begin
                    // enabled rails are always contiguous from 0, so a shift drops the highest
                    state_nxt   = S_DOWN;
                    rail_en_nxt = rail_en >> 1;
                    qual_nxt    = '0;
                    tmr_nxt     = '0;
                end else if (qual_hit) begin
                    qual_nxt = '0;
                    tmr_nxt  = '0;
                    if (k == K_LAST) begin
                        state_nxt = S_ON;
                    end else begin
                        k_nxt       = k + K_ONE;
                        rail_en_nxt = (rail_en << 1) | EN_ONE;
                    end
                end else begin
                    // a low sample restarts qualification; the timeout keeps running
                    qual_nxt = rail_good[k] ? sat_inc(qual_cnt) : '0;
                    tmr_nxt  = sat_inc(tmr_cnt);
                end
            end

            S_ON: begin
                if (lo_all_vld) begin
                    state_nxt      = S_FAULT;
                    rail_en_nxt    = '0;
                    fault_nxt      = 1'b1;
                    fault_rail_nxt = lo_all_idx;
                    k_nxt          = '0;
                    tmr_nxt        = '0;
                end else if (!pwr_req) begin
                    state_nxt   = S_DOWN;
                    rail_en_nxt = rail_en >> 1;
                    tmr_nxt     = '0;
                end
            end

            S_DOWN: begin
                // rail_good is deliberately ignored while powering down
                if (tmr_cnt == DLY_LAST) begin
                    tmr_nxt = '0;
                    if (rail_en == '0) begin
                        state_nxt = S_IDLE;
                        k_nxt     = '0;
                    end else begin
                        rail_en_nxt = rail_en >> 1;
                    end
                end else begin
                    tmr_nxt = sat_inc(tmr_cnt);
                end
            end

            S_FAULT: begin
                rail_en_nxt = '0;
                if (!pwr_req) begin
                    state_nxt = S_IDLE;
                    fault_nxt = 1'b0;
                    k_nxt     = '0;
                    qual_nxt  = '0;
                    tmr_nxt   = '0;
                end
            end

            default: begin
                state_nxt   = S_IDLE;
                rail_en_nxt = '0;
                fault_nxt   = 1'b0;
                k_nxt       = '0;
                qual_nxt    = '0;
                tmr_nxt     = '0;
            end
        endcase
    end

    // Datapath registers: rail index, counters and the registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            k          <= '0;
            qual_cnt   <= '0;
            tmr_cnt    <= '0;
            rail_en    <= '0;
            fault      <= 1'b0;
            fault_rail <= '0;
        end else begin
            k          <= k_nxt;
            qual_cnt   <= qual_nxt;
            tmr_cnt    <= tmr_nxt;
            rail_en    <= rail_en_nxt;
            fault      <= fault_nxt;
            fault_rail <= fault_rail_nxt;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        all_good = (state == S_ON);
        busy     = (state == S_UP) || (state == S_DOWN);
    end

endmodule

// File: tb/tb_power_seq.sv
// Purpose: randomized and directed stimulus for power_seq, checked every cycle against a rail-count model.
// Latency: outputs compared 1ns after each rising edge; inputs re-driven right after that.
// Backpressure: n/a; a rail plant model drives rail_good from the expected enables.
module tb_power_seq;

    localparam int N = 4;
    localparam int D = 30;
    localparam int T = 100;

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_ON    = 2;
    localparam int M_DOWN  = 3;
    localparam int M_FAULT = 4;

    logic         clk = 1'b0;
    logic         resetb;
    logic         pwr_req;
    logic [N-1:0] rail_good;
    logic [N-1:0] rail_en;
    logic         all_good;
    logic         fault;
    logic [3:0]   fault_rail;
    logic         busy;

    always #5 clk = ~clk;

    power_seq #(.N_RAILS(N), .DELAY_CYC(D), .TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .pwr_req    (pwr_req),
        .rail_good  (rail_good),
        .rail_en    (rail_en),
        .all_good   (all_good),
        .fault      (fault),
        .fault_rail (fault_rail),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: number of enabled rails plus run/wait counts
    int   m_mode, m_n, m_run, m_wait, m_frail;
    logic m_fault;

    task automatic model_reset();
        m_mode = M_IDLE; m_n = 0; m_run = 0; m_wait = 0; m_fault = 1'b0; m_frail = 0;
    endtask

    function automatic int lowest_low(input logic [N-1:0] g, input int lim);
        for (int i = 0; i < lim; i++) if (!g[i]) return i;
        return -1;
    endfunction

    task automatic go_fault(input int j);
        m_mode = M_FAULT; m_n = 0; m_fault = 1'b1; m_frail = j;
    endtask

    task automatic model_edge();
        int j, run2, w2;
        case (m_mode)
            M_IDLE: if (pwr_req) begin m_mode = M_UP; m_n = 1; m_run = 0; m_wait = 0; end
            M_UP: begin
                j    = lowest_low(rail_good, m_n - 1);
                run2 = rail_good[m_n-1] ? m_run + 1 : 0;
                w2   = m_wait + 1;
                if (j >= 0) go_fault(j);
                else if (run2 < D && w2 >= T) go_fault(m_n - 1);
                else if (!pwr_req) begin m_mode = M_DOWN; m_n--; m_wait = 0; end
                else if (run2 >= D) begin
                    if (m_n == N) m_mode = M_ON; else m_n++;
                    m_run = 0; m_wait = 0;
                end else begin m_run = run2; m_wait = w2; end
            end
            M_ON: begin
                j = lowest_low(rail_good, N);
                if (j >= 0) go_fault(j);
                else if (!pwr_req) begin m_mode = M_DOWN; m_n--; m_wait = 0; end
            end
            M_DOWN: begin
                w2 = m_wait + 1;
                if (w2 >= D) begin
                    if (m_n == 0) m_mode = M_IDLE; else m_n--;
                    m_wait = 0;
                end else m_wait = w2;
            end
            default: if (!pwr_req) begin m_mode = M_IDLE; m_fault = 1'b0; end
        endcase
    endtask

    function automatic logic [N-1:0] exp_en();
        return N'((1 << m_n) - 1);
    endfunction

    // Rail plant: each enabled rail reports good dly cycles after enable
    int           cnt [N];
    int           dly [N];
    logic [N-1:0] prev_en;
    int           fix_dly, stuck, glitch_pm;

    task automatic plant_update();
        logic [N-1:0] en;
        logic g;
        en = exp_en();
        for (int i = 0; i < N; i++) begin
            if (!en[i]) begin
                cnt[i] = 0; rail_good[i] = 1'b0;
            end else begin
                if (!prev_en[i]) begin
                    cnt[i] = 0;
                    if (i == stuck)        dly[i] = 1000;
                    else if (fix_dly >= 0) dly[i] = fix_dly;
                    else dly[i] = ($urandom_range(0, 7) == 0) ? 150 : int'($urandom_range(0, 12));
                end else if (cnt[i] < 100000) cnt[i]++;
                g = (cnt[i] >= dly[i]);
                if (glitch_pm > 0 && int'($urandom_range(0, 999)) < glitch_pm) g = 1'b0;
                rail_good[i] = g;
            end
        end
        prev_en = en;
    endtask

    task automatic compare_all();
        chk("rail_en",    rail_en,    exp_en());
        chk("all_good",   all_good,   m_mode == M_ON);
        chk("busy",       busy,       m_mode == M_UP || m_mode == M_DOWN);
        chk("fault",      fault,      m_fault);
        chk("fault_rail", fault_rail, m_frail);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        plant_update();
    endtask

    function automatic logic [3:0] cur(input int sel);
        case (sel)
            0:       return rail_en;
            1:       return {3'b0, all_good};
            2:       return {3'b0, fault};
            default: return {3'b0, busy};
        endcase
    endfunction

    // Steps until the selected output equals val; n = steps taken
    task automatic wait_for(input int sel, input logic [3:0] val, input int budget, input string tag, output int n);
        n = 0;
        do begin step(); n++; end while (cur(sel) !== val && n < budget);
        chk(tag, cur(sel), val);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic do_arst(input string tag);
        #2 resetb = 1'b0;
        #1;
        chk({tag, "_en"},   rail_en,  '0);
        chk({tag, "_busy"}, busy,     1'b0);
        chk({tag, "_ag"},   all_good, 1'b0);
        chk({tag, "_flt"},  fault,    1'b0);
        chk({tag, "_fr"},   fault_rail, 4'd0);
        model_reset();
        rail_good = '0; prev_en = '0;
        #1 resetb = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=stalled expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, k;
        resetb = 1'b0; pwr_req = 1'b0; rail_good = '0; prev_en = '0;
        fix_dly = 5; stuck = -1; glitch_pm = 0;
        for (int i = 0; i < N; i++) begin cnt[i] = 0; dly[i] = 0; end
        model_reset();
        #1;
        chk("rst_en", rail_en, '0);
        chk("rst_ag", all_good, 1'b0);
        chk("rst_flt", fault, 1'b0);
        chk("rst_fr", fault_rail, 4'd0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); @(posedge clk); #1 resetb = 1'b1;

        // Clean power-up: 35 cycles per rail, all_good 140 after pwr_req sampled
        pwr_req = 1'b1;
        wait_for(0, 4'b0001, 5, "up_en0", n);   chk("up_en0_lat", n, 1);
        acc = 0;
        wait_for(0, 4'b0011, 200, "up_en1", n); chk("up_en1_gap", n, 35); acc += n;
        wait_for(0, 4'b0111, 200, "up_en2", n); chk("up_en2_gap", n, 35); acc += n;
        wait_for(0, 4'b1111, 200, "up_en3", n); chk("up_en3_gap", n, 35); acc += n;
        wait_for(1, 4'b0001, 200, "up_ag", n);  acc += n;
        chk("up_ag_lat", acc, 140);
        chk("up_noflt", fault, 1'b0);

        // Power-down from ON at 30-cycle spacing
        pwr_req = 1'b0;
        wait_for(0, 4'b0111, 5, "dn_0111", n);   chk("dn_first", n, 1);
        chk("dn_ag", all_good, 1'b0);
        wait_for(0, 4'b0011, 100, "dn_0011", n); chk("dn_gap1", n, 30);
        wait_for(0, 4'b0001, 100, "dn_0001", n); chk("dn_gap2", n, 30);
        wait_for(0, 4'b0000, 100, "dn_0000", n); chk("dn_gap3", n, 30);
        wait_for(3, 4'b0000, 100, "dn_idle", n); chk("dn_idle_gap", n, 30);

        // Glitch on rail 1 at run count 20 delays rail 2 by 21 cycles
        pwr_req = 1'b1;
        wait_for(0, 4'b0001, 5, "gl_en0", n);
        wait_for(0, 4'b0011, 200, "gl_en1", n);
        k = 0;
        while (!(m_n == 2 && m_run == 20) && k < 60) begin step(); k++; end
        rail_good[1] = 1'b0;
        wait_for(0, 4'b0111, 200, "gl_en2", n);
        chk("gl_gap", k + n, 56);
        chk("gl_noflt", fault, 1'b0);
        wait_for(0, 4'b1111, 200, "gl_en3", n);
        wait_for(1, 4'b0001, 200, "gl_ag", n);

        // ON drop on rail 3
        rail_good[3] = 1'b0;
        step();
        chk("ond_en", rail_en, 4'b0000);
        chk("ond_ag", all_good, 1'b0);
        chk("ond_flt", fault, 1'b1);
        chk("ond_fr", fault_rail, 4'd3);
        pwr_req = 1'b0;
        step();
        chk("ond_clr", fault, 1'b0);

        // Timeout on rail 2
        stuck = 2;
        pwr_req = 1'b1;
        wait_for(0, 4'b0001, 5, "to_en0", n);
        wait_for(0, 4'b0011, 200, "to_en1", n);
        wait_for(0, 4'b0111, 200, "to_en2", n);
        wait_for(2, 4'b0001, 200, "to_flt", n);
        chk("to_lat", n, 100);
        chk("to_en", rail_en, 4'b0000);
        chk("to_fr", fault_rail, 4'd2);
        chk("to_busy", busy, 1'b0);
        pwr_req = 1'b0;
        step();
        chk("to_clr", fault, 1'b0);
        chk("to_fr_hold", fault_rail, 4'd2);
        stuck = -1;

        // Async reset mid-UP, then pwr_req sampled on the first edge after release
        pwr_req = 1'b1;
        wait_for(0, 4'b0011, 200, "ar_en1", n);
        for (int i = 0; i < 7; i++) step();
        do_arst("arst");
        step();
        chk("ar_restart", rail_en, 4'b0001);

        // Randomized run
        fix_dly = -1; glitch_pm = 3;
        for (int c = 0; c < 12000; c++) begin
            if (pwr_req && $urandom_range(0, 149) == 0) pwr_req = 1'b0;
            else if (!pwr_req && $urandom_range(0, 39) == 0) pwr_req = 1'b1;
            if ($urandom_range(0, 2999) == 0) do_arst("rnd_arst");
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
